// File: rtl/dvi_pkg.sv
// Shared constants and helpers for the DVI TMDS encoder: widths, the four
// control tokens and a popcount used by the minimisation and balance stages.
package dvi_pkg;

    localparam int TMDS_W = 10;
    localparam int PIX_W  = 8;

    localparam logic [TMDS_W-1:0] CTRL_00 = 10'b1101010100;
    localparam logic [TMDS_W-1:0] CTRL_01 = 10'b0010101011;
    localparam logic [TMDS_W-1:0] CTRL_10 = 10'b0101010100;
    localparam logic [TMDS_W-1:0] CTRL_11 = 10'b1010101011;

    function automatic logic [3:0] popcount8(input logic [PIX_W-1:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < PIX_W; i++) begin
            n = n + {3'd0, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/dvi_tmds_encoder_if.sv
// Pixel/timing bundle from the source plus the three TMDS characters going
// to the serializer; master is the pixel source, slave is the encoder.
interface dvi_tmds_encoder_if;
    import dvi_pkg::*;

    logic [PIX_W-1:0]  red;
    logic [PIX_W-1:0]  green;
    logic [PIX_W-1:0]  blue;
    logic              hsync;
    logic              vsync;
    logic              de;
    logic [TMDS_W-1:0] tmds_red;
    logic [TMDS_W-1:0] tmds_green;
    logic [TMDS_W-1:0] tmds_blue;

    modport master (
        output red, green, blue, hsync, vsync, de,
        input  tmds_red, tmds_green, tmds_blue
    );

    modport slave (
        input  red, green, blue, hsync, vsync, de,
        output tmds_red, tmds_green, tmds_blue
    );

endinterface

// File: rtl/tmds_channel_encoder.sv
// One TMDS channel: stage 1 minimises transitions, stage 2 picks polarity to
// keep the running disparity balanced or emits a control token in blanking.
module tmds_channel_encoder
    import dvi_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic [PIX_W-1:0]  d,
    input  logic [1:0]        c,
    input  logic              de,
    output logic [TMDS_W-1:0] q
);

    function automatic logic [8:0] minimise(input logic [PIX_W-1:0] v);
        logic [3:0] n;
        logic       use_xnor;
        logic [8:0] m;
        n        = popcount8(v);
        use_xnor = (n > 4'd4) || ((n == 4'd4) && !v[0]);
        m        = 9'd0;
        m[0]     = v[0];
        for (int i = 1; i < PIX_W; i++) begin
            m[i] = use_xnor ? ~(m[i-1] ^ v[i]) : (m[i-1] ^ v[i]);
        end
        m[8] = ~use_xnor;
        return m;
    endfunction

    logic [8:0]        qm_r;
    logic [3:0]        n1_r;
    logic              de_r;
    logic [1:0]        c_r;
    logic signed [5:0] cnt;
    logic signed [5:0] cnt_next;
    logic signed [5:0] bal;
    logic signed [5:0] two_qm8;
    logic [TMDS_W-1:0] q_next;

    always_ff @(posedge clock) begin
        if (reset) begin
            qm_r <= 9'd0;
            n1_r <= 4'd0;
            de_r <= 1'b0;
            c_r  <= 2'b00;
        end else begin
            qm_r <= minimise(d);
            n1_r <= popcount8(minimise(d)[7:0]);
            de_r <= de;
            c_r  <= c;
        end
    end

    // bal is N1-N0 of the minimised byte, i.e. 2*N1-8
    always_comb begin
        bal      = $signed({1'b0, n1_r, 1'b0}) - 6'sd8;
        two_qm8  = qm_r[8] ? 6'sd2 : 6'sd0;
        q_next   = CTRL_00;
        cnt_next = cnt;
        if (!de_r) begin
            cnt_next = 6'sd0;
            case (c_r)
                2'b00:   q_next = CTRL_00;
                2'b01:   q_next = CTRL_01;
                2'b10:   q_next = CTRL_10;
                default: q_next = CTRL_11;
            endcase
        end else if ((cnt == 6'sd0) || (bal == 6'sd0)) begin
            q_next   = {~qm_r[8], qm_r[8], qm_r[8] ? qm_r[7:0] : ~qm_r[7:0]};
            cnt_next = qm_r[8] ? (cnt + bal) : (cnt - bal);
        end else if (((cnt > 6'sd0) && (bal > 6'sd0)) || ((cnt < 6'sd0) && (bal < 6'sd0))) begin
            q_next   = {1'b1, qm_r[8], ~qm_r[7:0]};
            cnt_next = cnt + two_qm8 - bal;
        end else begin
            q_next   = {1'b0, qm_r[8], qm_r[7:0]};
            cnt_next = cnt + bal - (6'sd2 - two_qm8);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            q   <= CTRL_00;
            cnt <= 6'sd0;
        end else begin
            q   <= q_next;
            cnt <= cnt_next;
        end
    end

endmodule

// File: rtl/dvi_tmds_encoder.sv
// DVI TMDS encoder top: three channel encoders, syncs carried on blue only,
// two-clock fixed latency from pixel inputs to characters.
module dvi_tmds_encoder
    import dvi_pkg::*;
(
    input  logic                clock,
    input  logic                reset,
    dvi_tmds_encoder_if.slave   bus
);

    tmds_channel_encoder u_blue (
        .clock (clock),
        .reset (reset),
        .d     (bus.blue),
        .c     ({bus.vsync, bus.hsync}),
        .de    (bus.de),
        .q     (bus.tmds_blue)
    );

    tmds_channel_encoder u_green (
        .clock (clock),
        .reset (reset),
        .d     (bus.green),
        .c     (2'b00),
        .de    (bus.de),
        .q     (bus.tmds_green)
    );

    tmds_channel_encoder u_red (
        .clock (clock),
        .reset (reset),
        .d     (bus.red),
        .c     (2'b00),
        .de    (bus.de),
        .q     (bus.tmds_red)
    );

endmodule

// File: tb/tb_dvi_tmds_encoder.sv
// Bench for dvi_tmds_encoder: directed steps feed a reference encoder whose
// expected characters wait in a scoreboard queue for the 2-clock latency.
module tb_dvi_tmds_encoder;

    typedef struct {
        logic [9:0] r;
        logic [9:0] g;
        logic [9:0] b;
        logic       de;
        logic [7:0] dr;
        logic [7:0] dg;
        logic [7:0] db;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   errors = 0;
    int   checks = 0;
    int   cnt_r = 0;
    int   cnt_g = 0;
    int   cnt_b = 0;
    exp_t sb[$];

    dvi_tmds_encoder_if bus ();

    dvi_tmds_encoder dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;

    task automatic model_char(input logic [7:0] d, input logic de_i, input logic [1:0] c,
                              input int cnt_in, output logic [9:0] ch, output int cnt_out);
        int ones;
        int n1;
        int n0;
        logic use_xnor;
        logic [7:0] qm;
        logic qm8;
        ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(d[i]);
        use_xnor = (ones > 4) || (ones == 4 && d[0] == 1'b0);
        qm[0] = d[0];
        for (int i = 1; i < 8; i++) qm[i] = use_xnor ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
        qm8 = !use_xnor;
        n1 = 0;
        for (int i = 0; i < 8; i++) n1 += int'(qm[i]);
        n0 = 8 - n1;
        cnt_out = cnt_in;
        if (!de_i) begin
            cnt_out = 0;
            case (c)
                2'b00:   ch = 10'b1101010100;
                2'b01:   ch = 10'b0010101011;
                2'b10:   ch = 10'b0101010100;
                default: ch = 10'b1010101011;
            endcase
        end else if (cnt_in == 0 || n1 == n0) begin
            if (qm8) begin
                ch = {2'b01, qm};
                cnt_out = cnt_in + n1 - n0;
            end else begin
                ch = {2'b10, ~qm};
                cnt_out = cnt_in + n0 - n1;
            end
        end else if ((cnt_in > 0 && n1 > n0) || (cnt_in < 0 && n0 > n1)) begin
            ch = {1'b1, qm8, ~qm};
            cnt_out = cnt_in + (qm8 ? 2 : 0) + n0 - n1;
        end else begin
            ch = {1'b0, qm8, qm};
            cnt_out = cnt_in - (qm8 ? 0 : 2) + n1 - n0;
        end
    endtask

    function automatic logic [7:0] decode(input logic [9:0] ch);
        logic [7:0] qm;
        logic [7:0] d;
        qm = ch[9] ? ~ch[7:0] : ch[7:0];
        d[0] = qm[0];
        for (int i = 1; i < 8; i++) d[i] = ch[8] ? (qm[i] ^ qm[i-1]) : ~(qm[i] ^ qm[i-1]);
        return d;
    endfunction

    task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_output();
        exp_t e;
        if (sb.size() < 2) begin
            checks++;
            errors++;
            $error("[TB] FAIL scoreboard: observed=%0d entries expected>=2", sb.size());
            return;
        end
        e = sb.pop_front();
        chk("tmds_red",   bus.tmds_red,   e.r);
        chk("tmds_green", bus.tmds_green, e.g);
        chk("tmds_blue",  bus.tmds_blue,  e.b);
        if (e.de) begin
            chk("decode_red",   {2'b00, decode(bus.tmds_red)},   {2'b00, e.dr});
            chk("decode_green", {2'b00, decode(bus.tmds_green)}, {2'b00, e.dg});
            chk("decode_blue",  {2'b00, decode(bus.tmds_blue)},  {2'b00, e.db});
        end
    endtask

    task automatic apply_stimulus(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                                  input logic hs, input logic vs, input logic de_i);
        exp_t e;
        bus.red   = r;
        bus.green = g;
        bus.blue  = b;
        bus.hsync = hs;
        bus.vsync = vs;
        bus.de    = de_i;
        model_char(r, de_i, 2'b00,    cnt_r, e.r, cnt_r);
        model_char(g, de_i, 2'b00,    cnt_g, e.g, cnt_g);
        model_char(b, de_i, {vs, hs}, cnt_b, e.b, cnt_b);
        e.de = de_i;
        e.dr = r;
        e.dg = g;
        e.db = b;
        sb.push_back(e);
        @(posedge clock);
        #1;
        check_output();
    endtask

    task automatic apply_reset(input int cycles);
        exp_t e;
        reset = 1'b1;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clock);
            #1;
            chk("reset_red",   bus.tmds_red,   10'b1101010100);
            chk("reset_green", bus.tmds_green, 10'b1101010100);
            chk("reset_blue",  bus.tmds_blue,  10'b1101010100);
        end
        reset = 1'b0;
        sb.delete();
        cnt_r = 0;
        cnt_g = 0;
        cnt_b = 0;
        e.r  = 10'b1101010100;
        e.g  = 10'b1101010100;
        e.b  = 10'b1101010100;
        e.de = 1'b0;
        e.dr = 8'h00;
        e.dg = 8'h00;
        e.db = 8'h00;
        sb.push_back(e);
    endtask

    initial begin
        bus.red   = 8'h00;
        bus.green = 8'h00;
        bus.blue  = 8'h00;
        bus.hsync = 1'b0;
        bus.vsync = 1'b0;
        bus.de    = 1'b0;
        apply_reset(2);

        // hsync-only blanking, then blue 0x00 twice to walk cnt 0 -> -8 -> +2
        for (int i = 0; i < 3; i++) apply_stimulus(8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
        apply_stimulus(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
        apply_stimulus(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);

        // green 0xFF straight after blanking
        for (int i = 0; i < 2; i++) apply_stimulus(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        apply_stimulus(8'h10, 8'hFF, 8'h81, 1'b0, 1'b0, 1'b1);
        apply_stimulus(8'h3C, 8'hFF, 8'hA5, 1'b0, 1'b0, 1'b1);

        // all four sync combinations in blanking
        for (int s = 0; s < 4; s++) begin
            apply_stimulus(8'hAA, 8'h55, 8'hFF, s[0], s[1], 1'b0);
            apply_stimulus(8'h00, 8'h00, 8'h00, s[0], s[1], 1'b0);
        end

        // single-cycle de pulse
        apply_stimulus(8'hF0, 8'h0F, 8'h37, 1'b0, 1'b0, 1'b1);
        apply_stimulus(8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);

        for (int i = 0; i < 1000; i++) begin
            apply_stimulus(8'($urandom), 8'($urandom), 8'($urandom), 1'b0, 1'b0, 1'b1);
        end
        apply_stimulus(8'h00, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0);

        // mid-line reset: disparity must restart from zero afterwards
        for (int i = 0; i < 5; i++) apply_stimulus(8'($urandom), 8'($urandom), 8'($urandom), 1'b0, 1'b0, 1'b1);
        apply_reset(1);
        apply_stimulus(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
        apply_stimulus(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
        apply_stimulus(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        apply_stimulus(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dvi_tmds_encoder.md
Name: dvi_tmds_encoder

Overview:
- Downstream consumer of the pixel/timing source (dvi_stimulate): takes 8-bit red/green/blue plus hsync, vsync and a data-enable.
- Produces three 10-bit TMDS characters per pixel clock (DVI 1.0 8b/10b encoding with running DC balance).
- Feeds the serializer/transmitter; one character per channel per clock, fixed pipeline latency.

Parameters:
- none (DVI encoding is fixed; tokens and widths are constants in the package)

Ports:
- clock  input  1  pixel clock; all state updates on rising edge
- reset  input  1  synchronous, active-high
- red    input  8  red pixel, valid when de=1
- green  input  8  green pixel, valid when de=1
- blue   input  8  blue pixel, valid when de=1
- hsync  input  1  horizontal sync, carried as C0 on blue channel
- vsync  input  1  vertical sync, carried as C1 on blue channel
- de     input  1  data enable: 1 = active video, 0 = blanking/control period
- tmds_red    output 10  channel 2 character, bit 0 transmitted first
- tmds_green  output 10  channel 1 character
- tmds_blue   output 10  channel 0 character

Behaviour:
- Latency: exactly 2 clocks from inputs sampled to the corresponding character on the outputs. No stalls, no handshake; every clock accepts one input set.
- Stage 1 (registered), per channel, with n1(D) = ones in D[7:0]:
  - if n1>4 or (n1==4 and D[0]==0): XNOR chain, q_m[0]=D[0], q_m[i]=q_m[i-1] XNOR D[i], q_m[8]=0
  - else: XOR chain, q_m[8]=1
  - Register q_m, n1(q_m[7:0]), de, {c1,c0}.
- Stage 2 (registered), per channel, signed 6-bit running disparity cnt, with N1=n1(q_m[7:0]), N0=8-N1:
  - de=0: output control token; cnt <= 0. Tokens for {c1,c0}: 00 -> 1101010100, 01 -> 0010101011, 10 -> 0101010100, 11 -> 1010101011.
  - de=1, cnt==0 or N1==N0: out = {~q_m[8], q_m[8], q_m[8] ? q_m[7:0] : ~q_m[7:0]}; cnt += q_m[8] ? (N1-N0) : (N0-N1).
  - de=1, (cnt>0 and N1>N0) or (cnt<0 and N0>N1): out = {1, q_m[8], ~q_m[7:0]}; cnt += 2*q_m[8] + (N0-N1).
  - de=1, otherwise: out = {0, q_m[8], q_m[7:0]}; cnt += -2*(~q_m[8]) + (N1-N0).
- Control mapping: blue channel c0=hsync, c1=vsync; green and red channels have c1=c0=0.
- Each channel keeps its own cnt. |cnt| stays ≤ 16, so 6-bit signed never wraps.
- Reset:
  - all outputs = 1101010100 (token 00); all cnt = 0
  - stage-1 de = 0, stage-1 control = 00
  - first valid input character appears 2 clocks after reset deasserts
  - reset mid-frame discards in-flight pipeline contents and zeroes disparity
- de transitions: blanking-to-active starts with cnt=0, because the blanking period cleared it. A single-cycle de pulse is encoded normally.

Decomposition:
- Package dvi_pkg holds:
  - TMDS_W=10, PIX_W=8
  - the four control token constants CTRL_00..CTRL_11
  - a function popcount8
- Sub-module tmds_channel_encoder (clock, reset, d[7:0], c[1:0], de -> q[9:0]) implements both stages for one channel. It is instantiated three times; dvi_tmds_encoder only wires channels and control bits.

Test Plan:
- Reset held 2 clocks -> all three outputs 1101010100; de=0 with hsync=1, vsync=0 -> tmds_blue=0010101011 two clocks later, red/green=1101010100.
- After blanking, de=1, blue=0x00 for two clocks -> tmds_blue=0100000000 then 1111111111 (cnt 0 -> -8 -> +2).
- After blanking, de=1, green=0xFF -> tmds_green=1000000000, cnt=-8.
- Random RGB stream with de=1 for 1000 clocks -> each output matches a reference-model encoder at 2-clock offset; decoded data equals input; running disparity stays within ±16.
- hsync/vsync all four combinations during de=0 -> tmds_blue follows the token table at 2-clock latency; red/green constant 1101010100.
- Assert reset for one clock mid-active-line -> next 2 output cycles are 1101010100; subsequent encoding restarts with cnt=0 (0x00 again gives 0100000000).
